// File: rtl/bubble_sort_ctrl.sv
// Sequencing initiator that bubble-sorts a 2**ADDR_WIDTH-entry memory.
// It drives an external compare-and-swap unit one adjacent pair at a time and exits early after a pass with no swap.
module bubble_sort_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  cas_finish,
  input  logic                  cas_we,
  output logic                  cas_start,
  output logic [ADDR_WIDTH:0]   cas_i,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   pass_count
);

  localparam int N   = 2 ** ADDR_WIDTH;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH:0] PAIR_LAST = AW1'(N - 2);
  localparam logic [ADDR_WIDTH:0] MAX_PASS  = AW1'(N - 1);
  localparam logic [CW-1:0]       WAIT_MAX  = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   i_q, i_d;
  logic [ADDR_WIDTH:0]   pass_count_q, pass_count_d;
  logic                  swapped_q, swapped_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   limit;

  // Each pass leaves the largest remaining element at the end, so the last pair index shrinks by one per pass.
  assign limit = PAIR_LAST - pass_count_q;

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    pass_count_d = pass_count_q;
    swapped_d    = swapped_q;
    wait_cnt_d   = wait_cnt_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          i_d          = '0;
          pass_count_d = '0;
          swapped_d    = 1'b0;
          error_d      = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (cas_we) begin
          swapped_d = 1'b1;
        end
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (cas_finish) begin
          state_d = S_NEXT;
        end else if (wait_cnt_d == WAIT_MAX) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_NEXT: begin
        // Passing through NEXT also gives the responder one idle cycle before the next start.
        if (i_q < limit) begin
          i_d     = i_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          pass_count_d = pass_count_q + 1'b1;
          if (!swapped_q || (pass_count_d == MAX_PASS)) begin
            state_d = S_DONE;
          end else begin
            i_d       = '0;
            swapped_d = 1'b0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (go) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      pass_count_q <= '0;
      swapped_q    <= 1'b0;
      wait_cnt_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      pass_count_q <= pass_count_d;
      swapped_q    <= swapped_d;
      wait_cnt_q   <= wait_cnt_d;
      error_q      <= error_d;
    end
  end

  assign cas_start  = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign error      = error_q;
  assign cas_i      = i_q;
  assign pass_count = pass_count_q;

  // Index and pass bounds that keep cas_i+1 inside the memory.
  a_index_bound: assert property (@(posedge clk) disable iff (reset) cas_i <= PAIR_LAST);
  a_pass_bound:  assert property (@(posedge clk) disable iff (reset) pass_count <= MAX_PASS);
  a_start_idle:  assert property (@(posedge clk) disable iff (reset) !(cas_start && (done || error)));

endmodule
